fir_tap_sequencer: RTL and testbench

- Control FSM that time-multiplexes the single-multiplier FIR MAC datapath (compute) of one equalizer band.
- Accepts one input sample per handshake and writes it into an external circular delay-line RAM.
- Walks all NUMBER_OF_TAPS taps, driving delay-line read address, coefficient address, phase_min and clk_enable; flushes the accumulator and pulses out_valid when filter_out is valid.
- After reset, zero-fills the delay line before accepting samples.

---
 rtl/fir_tap_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_fir_tap_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_tap_sequencer.sv
// ---------------------------------------------------------------------------
// fir_tap_sequencer
//
// Control FSM for one equalizer band's single-multiplier FIR MAC datapath.
// It accepts one sample per handshake and writes it into an external circular
// delay-line RAM. It then walks every tap, driving the delay-line read address,
// the coefficient index, phase_min and mac_en. A flush cycle follows, and then
// out_valid pulses for one cycle. After reset the delay line is zero-filled
// before any sample is accepted.
//
// Parameters
//   NUMBER_OF_TAPS  taps per filter (>= 2, any value)
//   FILTER_IN_BITS  sample width
//   ADDR_BITS       address width, 2**ADDR_BITS >= NUMBER_OF_TAPS
//
// Ports
//   clk_i          system clock, rising edge
//   rst_ni         asynchronous active-low reset
//   in_valid_i     new sample offered
//   in_sample_i    signed sample
//   in_ready_o     sample can be accepted this cycle (IDLE)
//   dl_we_o        delay-line write enable
//   dl_wr_addr_o   delay-line write address
//   dl_wdata_o     delay-line write data
//   dl_rd_addr_o   delay-line read address (combinational RAM read)
//   coeff_addr_o   coefficient index k (combinational ROM read)
//   phase_min_o    compute: first tap, or flush
//   mac_en_o       compute clock enable
//   out_valid_o    one-cycle pulse: compute filter_out holds the new result
//   busy_o         state != IDLE
//   overrun_o      sticky: sample offered while not ready
//   clr_overrun_i  synchronous clear of overrun_o
// ---------------------------------------------------------------------------
module fir_tap_sequencer #(
    parameter int NUMBER_OF_TAPS = 64,
    parameter int FILTER_IN_BITS = 16,
    parameter int ADDR_BITS      = 6
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             in_valid_i,
    input  logic signed [FILTER_IN_BITS-1:0] in_sample_i,
    output logic                             in_ready_o,
    output logic                             dl_we_o,
    output logic        [ADDR_BITS-1:0]      dl_wr_addr_o,
    output logic signed [FILTER_IN_BITS-1:0] dl_wdata_o,
    output logic        [ADDR_BITS-1:0]      dl_rd_addr_o,
    output logic        [ADDR_BITS-1:0]      coeff_addr_o,
    output logic                             phase_min_o,
    output logic                             mac_en_o,
    output logic                             out_valid_o,
    output logic                             busy_o,
    output logic                             overrun_o,
    input  logic                             clr_overrun_i
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_MAC   = 2'd2,
        ST_FLUSH = 2'd3
    } state_e;

    localparam logic [ADDR_BITS-1:0] LAST_IDX = ADDR_BITS'(NUMBER_OF_TAPS - 1);
    localparam logic [ADDR_BITS-1:0] ONE      = ADDR_BITS'(1);

    state_e               state_q,     state_d;
    logic [ADDR_BITS-1:0] init_cnt_q,  init_cnt_d;
    logic [ADDR_BITS-1:0] wr_ptr_q,    wr_ptr_d;
    logic [ADDR_BITS-1:0] newest_q,    newest_d;
    logic [ADDR_BITS-1:0] tap_k_q,     tap_k_d;
    logic [ADDR_BITS-1:0] rd_ptr_q,    rd_ptr_d;
    logic                 out_valid_q, out_valid_d;
    logic                 overrun_q,   overrun_d;

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            newest_q    <= '0;
            tap_k_q     <= '0;
            rd_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            newest_q    <= newest_d;
            tap_k_q     <= tap_k_d;
            rd_ptr_q    <= rd_ptr_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and datapath-control outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        init_cnt_d   = init_cnt_q;
        wr_ptr_d     = wr_ptr_q;
        newest_d     = newest_q;
        tap_k_d      = tap_k_q;
        rd_ptr_d     = rd_ptr_q;
        out_valid_d  = 1'b0;

        in_ready_o   = 1'b0;
        dl_we_o      = 1'b0;
        dl_wr_addr_o = wr_ptr_q;
        dl_wdata_o   = '0;
        mac_en_o     = 1'b0;
        phase_min_o  = 1'b0;

        case (state_q)
            ST_INIT: begin
                // Zero one delay-line entry per cycle.
                dl_we_o      = 1'b1;
                dl_wr_addr_o = init_cnt_q;
                if (init_cnt_q == LAST_IDX) begin
                    init_cnt_d = '0;
                    state_d    = ST_IDLE;
                end else begin
                    init_cnt_d = init_cnt_q + ONE;
                end
            end

            ST_IDLE: begin
                in_ready_o = 1'b1;
                dl_we_o    = in_valid_i;
                dl_wdata_o = in_sample_i;
                if (in_valid_i) begin
                    newest_d = wr_ptr_q;
                    wr_ptr_d = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + ONE;
                    tap_k_d  = '0;
                    // Read pointer starts on the sample being written now
                    // and walks backwards through the history.
                    rd_ptr_d = wr_ptr_q;
                    state_d  = ST_MAC;
                end
            end

            ST_MAC: begin
                mac_en_o    = 1'b1;
                phase_min_o = (tap_k_q == '0);
                // Down-counting pointer gives (newest - k) mod taps with
                // a single wrap check instead of a modulo.
                rd_ptr_d    = (rd_ptr_q == '0) ? LAST_IDX : rd_ptr_q - ONE;
                if (tap_k_q == LAST_IDX) begin
                    tap_k_d = '0;
                    state_d = ST_FLUSH;
                end else begin
                    tap_k_d = tap_k_q + ONE;
                end
            end

            ST_FLUSH: begin
                // phase_min without mac_en: accumulator holds, final
                // register captures the complete sum.
                phase_min_o = 1'b1;
                out_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end

            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Sticky overrun; a new violation wins over a simultaneous clear.
    always_comb begin
        overrun_d = overrun_q;
        if (in_valid_i && !in_ready_o) begin
            overrun_d = 1'b1;
        end else if (clr_overrun_i) begin
            overrun_d = 1'b0;
        end
    end

    // Outside MAC the read address parks on the newest sample, which keeps
    // it defined from reset onward.
    assign dl_rd_addr_o = (state_q == ST_MAC) ? rd_ptr_q : newest_q;
    assign coeff_addr_o = tap_k_q;
    assign out_valid_o  = out_valid_q;
    assign overrun_o    = overrun_q;
    assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fir_tap_sequencer.sv
module tb_fir_tap_sequencer;

    localparam int N     = 5;
    localparam int W     = 16;
    localparam int AW    = 3;
    localparam int FRAC  = 14;          // coefficients in Q2.14
    localparam int BOUND = 4 * N + 16;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                in_valid;
    logic signed [W-1:0] in_sample;
    logic                in_ready;
    logic                dl_we;
    logic [AW-1:0]       dl_wr_addr;
    logic signed [W-1:0] dl_wdata;
    logic [AW-1:0]       dl_rd_addr;
    logic [AW-1:0]       coeff_addr;
    logic                phase_min;
    logic                mac_en;
    logic                out_valid;
    logic                busy;
    logic                overrun;
    logic                clr_overrun;

    always #5 clk = ~clk;

    fir_tap_sequencer #(
        .NUMBER_OF_TAPS(N),
        .FILTER_IN_BITS(W),
        .ADDR_BITS     (AW)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .in_valid_i   (in_valid),
        .in_sample_i  (in_sample),
        .in_ready_o   (in_ready),
        .dl_we_o      (dl_we),
        .dl_wr_addr_o (dl_wr_addr),
        .dl_wdata_o   (dl_wdata),
        .dl_rd_addr_o (dl_rd_addr),
        .coeff_addr_o (coeff_addr),
        .phase_min_o  (phase_min),
        .mac_en_o     (mac_en),
        .out_valid_o  (out_valid),
        .busy_o       (busy),
        .overrun_o    (overrun),
        .clr_overrun_i(clr_overrun)
    );

    // ---------------- external delay line, coefficient ROM, MAC ------------
    int     coeff [N];
    int     dl_mem[N];
    longint prod, acc, acc_final;
    int     filter_out;

    function automatic int sat_floor(input longint a);
        longint s;
        s = a >>> FRAC;
        if (s > 32767)  return 32767;
        if (s < -32768) return -32768;
        return int'(s);
    endfunction

    always @(posedge clk)
        if (dl_we && int'(dl_wr_addr) < N) dl_mem[int'(dl_wr_addr)] <= int'(dl_wdata);

    always_comb begin
        prod = 0;
        if (int'(coeff_addr) < N && int'(dl_rd_addr) < N)
            prod = longint'(coeff[int'(coeff_addr)]) * longint'(dl_mem[int'(dl_rd_addr)]);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= 0;
            acc_final <= 0;
        end else begin
            if (phase_min) acc_final <= acc;
            if (mac_en)    acc <= phase_min ? prod : acc + prod;
        end
    end

    assign filter_out = sat_floor(acc_final);

    // ---------------- reference model: plain convolution over history ------
    int hist[$];
    int n_acc;

    function automatic int golden();
        longint s = 0;
        for (int k = 0; k < N; k++)
            if (k < hist.size())
                s += longint'(coeff[k]) * longint'(hist[hist.size() - 1 - k]);
        return sat_floor(s);
    endfunction

    int n_vec = 0;
    int n_err = 0;

    int tr_rd[BOUND+1];
    int tr_ca[BOUND+1];
    bit tr_pm[BOUND+1];
    bit tr_me[BOUND+1];
    int last_wr;
    bit last_we;

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic rand_coeffs();
        for (int k = 0; k < N; k++) coeff[k] = int'($urandom_range(65535, 0)) - 32768;
    endtask

    task automatic reset_dut(output bit ok);
        int w = 0;
        rst_n = 1'b0; in_valid = 1'b0; clr_overrun = 1'b0; in_sample = '0;
        tick(); tick();
        rst_n = 1'b1;
        hist.delete(); n_acc = 0;
        while (!in_ready && w < BOUND) begin tick(); w++; end
        ok = in_ready;
    endtask

    // Offers one sample when ready, then follows it to out_valid, tracing
    // the control outputs of every cycle in between.
    task automatic send_sample(input int s, output int lat, output int fout, output bit ok);
        int w = 0;
        ok = 1'b0; lat = 0; fout = 0;
        while (!in_ready && w < BOUND) begin tick(); w++; end
        if (!in_ready) return;
        last_wr   = int'(dl_wr_addr);
        in_valid  = 1'b1;
        in_sample = W'(s);
        #1 last_we = dl_we;
        tick();
        in_valid = 1'b0;
        hist.push_back(s); n_acc++;
        lat = 1;
        while (!out_valid && lat < BOUND) begin
            tr_rd[lat] = int'(dl_rd_addr);
            tr_ca[lat] = int'(coeff_addr);
            tr_pm[lat] = phase_min;
            tr_me[lat] = mac_en;
            tick(); lat++;
        end
        ok = out_valid; fout = filter_out;
    endtask

    // ---------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; clr_overrun = 1'b0; in_sample = '0;
        tick();
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %0b expected 0", in_ready); end
        n_vec++; if (dl_we !== 1'b1) begin n_err++; $display("FAIL rst_dl_we: got %0b expected 1", dl_we); end
        n_vec++; if (dl_wr_addr !== '0) begin n_err++; $display("FAIL rst_wr_addr: got %0d expected 0", dl_wr_addr); end
        n_vec++; if (dl_rd_addr !== '0 || coeff_addr !== '0) begin n_err++; $display("FAIL rst_addrs: got rd=%0d k=%0d expected 0 0", dl_rd_addr, coeff_addr); end
        n_vec++; if ({mac_en, phase_min, out_valid, overrun} !== 4'b0000) begin n_err++; $display("FAIL rst_ctrl: got %b expected 0000", {mac_en, phase_min, out_valid, overrun}); end
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL rst_busy: got %0b expected 1", busy); end
        rst_n = 1'b1;
        hist.delete(); n_acc = 0;
        for (int i = 0; i < N; i++) begin
            n_vec++;
            if (dl_we !== 1'b1 || int'(dl_wr_addr) !== i || dl_wdata !== '0 || in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL init_cycle%0d: got we=%0b addr=%0d data=%0d rdy=%0b expected 1 %0d 0 0", i, dl_we, dl_wr_addr, dl_wdata, in_ready, i);
            end
            tick();
        end
        n_vec++; if (in_ready !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL init_done: got rdy=%0b busy=%0b expected 1 0", in_ready, busy); end
        $display("txn reset: %0d INIT cycles checked", N);
    endtask

    task automatic test_single();
        int lat, fout, newest, exp_rd;
        bit ok;
        reset_dut(ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL single_reset_timeout: got not-ready expected ready"); end
        for (int k = 0; k < N; k++) coeff[k] = 0;
        coeff[0] = 16384;
        send_sample(1000, lat, fout, ok);
        newest = (n_acc - 1) % N;
        n_vec++; if (!ok || lat != N + 2) begin n_err++; $display("FAIL single_latency: got %0d expected %0d", lat, N + 2); end
        n_vec++; if (fout != 1000) begin n_err++; $display("FAIL single_value: got %0d expected 1000", fout); end
        n_vec++; if (fout != golden()) begin n_err++; $display("FAIL single_model: got %0d expected %0d", fout, golden()); end
        n_vec++; if (last_wr != 0 || last_we !== 1'b1) begin n_err++; $display("FAIL single_write: got addr=%0d we=%0b expected 0 1", last_wr, last_we); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL single_ready_with_valid: got %0b expected 1", in_ready); end
        for (int c = 1; c <= N; c++) begin
            exp_rd = ((newest - (c - 1)) % N + N) % N;
            n_vec++;
            if (tr_me[c] !== 1'b1 || tr_pm[c] !== (c == 1) || tr_ca[c] != c - 1 || tr_rd[c] != exp_rd) begin
                n_err++;
                $display("FAIL single_mac%0d: got me=%0b pm=%0b k=%0d rd=%0d expected 1 %0b %0d %0d", c, tr_me[c], tr_pm[c], tr_ca[c], tr_rd[c], (c == 1), c - 1, exp_rd);
            end
        end
        n_vec++; if (tr_pm[N+1] !== 1'b1 || tr_me[N+1] !== 1'b0) begin n_err++; $display("FAIL single_flush: got pm=%0b me=%0b expected 1 0", tr_pm[N+1], tr_me[N+1]); end
        $display("txn single: sample=1000 out=%0d latency=%0d", fout, lat);
    endtask

    task automatic test_back_to_back();
        int acc_cyc[$];
        int rd6[$];
        int nout = 0, cyc = 0, newest6 = 0, exp_rd, exp_out;
        bit rec6 = 1'b0, pend_next = 1'b0, pend_stop = 1'b0, ok;
        reset_dut(ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL b2b_reset_timeout: got not-ready expected ready"); end
        rand_coeffs();
        in_valid  = 1'b1;
        in_sample = W'(int'($urandom_range(65535, 0)) - 32768);
        while (cyc < 7 * (N + 2) + BOUND && nout < 7) begin
            if (pend_next) begin in_sample = W'(int'($urandom_range(65535, 0)) - 32768); pend_next = 1'b0; end
            if (pend_stop) begin in_valid = 1'b0; pend_stop = 1'b0; end
            #1;
            if (rec6 && mac_en) rd6.push_back(int'(dl_rd_addr));
            if (out_valid) begin
                exp_out = golden();
                n_vec++; if (filter_out != exp_out || in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_out%0d: got %0d rdy=%0b expected %0d 1", nout, filter_out, in_ready, exp_out); end
                $display("txn b2b out%0d: value=%0d", nout, filter_out);
                nout++;
            end
            if (in_valid && in_ready) begin
                n_vec++; if (int'(dl_wr_addr) != n_acc % N) begin n_err++; $display("FAIL b2b_wr_ptr%0d: got %0d expected %0d", n_acc, dl_wr_addr, n_acc % N); end
                if (acc_cyc.size() > 0) begin
                    n_vec++; if (cyc - acc_cyc[$] != N + 2) begin n_err++; $display("FAIL b2b_spacing: got %0d expected %0d", cyc - acc_cyc[$], N + 2); end
                end
                acc_cyc.push_back(cyc);
                rec6 = (acc_cyc.size() == 6);
                if (rec6) newest6 = n_acc % N;
                hist.push_back(int'(in_sample)); n_acc++;
                if (acc_cyc.size() == 7) pend_stop = 1'b1; else pend_next = 1'b1;
            end
            tick(); cyc++;
        end
        n_vec++; if (nout != 7) begin n_err++; $display("FAIL b2b_count: got %0d expected 7", nout); end
        n_vec++; if (rd6.size() != N) begin n_err++; $display("FAIL b2b_rd6_len: got %0d expected %0d", rd6.size(), N); end
        for (int k = 0; k < rd6.size(); k++) begin
            exp_rd = ((newest6 - k) % N + N) % N;
            n_vec++; if (rd6[k] != exp_rd) begin n_err++; $display("FAIL b2b_rd6_k%0d: got %0d expected %0d", k, rd6[k], exp_rd); end
        end
        n_vec++; if (overrun !== 1'b1) begin n_err++; $display("FAIL b2b_overrun: got %0b expected 1", overrun); end
        in_valid = 1'b0;
        clr_overrun = 1'b1; tick(); clr_overrun = 1'b0;
    endtask

    task automatic test_overrun();
        int w = 0, exp_out;
        in_valid = 1'b0; clr_overrun = 1'b1; tick(); clr_overrun = 1'b0;
        for (int pass = 0; pass < 2; pass++) begin
            w = 0;
            while (!in_ready && w < BOUND) begin tick(); w++; end
            in_valid = 1'b1; in_sample = W'(int'($urandom_range(65535, 0)) - 32768);
            hist.push_back(int'(in_sample)); n_acc++;
            tick(); in_valid = 1'b0;          // MAC cycle 1
            tick();                           // MAC cycle 2
            if (pass == 0) tick();            // MAC cycle 3
            in_valid = 1'b1; in_sample = 16'sh5a5a;
            clr_overrun = (pass == 1);
            #1;
            n_vec++; if (dl_we !== 1'b0 || in_ready !== 1'b0) begin n_err++; $display("FAIL ovr%0d_no_write: got we=%0b rdy=%0b expected 0 0", pass, dl_we, in_ready); end
            tick(); in_valid = 1'b0; clr_overrun = 1'b0;
            n_vec++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr%0d_set: got %0b expected 1", pass, overrun); end
            w = 0;
            while (!out_valid && w < BOUND) begin tick(); w++; end
            exp_out = golden();
            n_vec++; if (!out_valid || filter_out != exp_out) begin n_err++; $display("FAIL ovr%0d_result: got %0d valid=%0b expected %0d", pass, filter_out, out_valid, exp_out); end
            n_vec++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr%0d_sticky: got %0b expected 1", pass, overrun); end
            clr_overrun = 1'b1; tick(); clr_overrun = 1'b0;
            n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr%0d_clear: got %0b expected 0", pass, overrun); end
            $display("txn overrun pass%0d: out=%0d", pass, filter_out);
        end
    endtask

    task automatic test_reset_mid_mac();
        int w = 0, c = 0, lat, fout, exp_out;
        bit saw_valid = 1'b0, ok;
        while (!in_ready && w < BOUND) begin tick(); w++; end
        in_valid = 1'b1; in_sample = 16'sd7777;
        tick(); in_valid = 1'b0;
        tick(); tick();                       // MAC cycle 3
        rst_n = 1'b0;
        #1;
        n_vec++; if ({in_ready, dl_we, mac_en, phase_min, out_valid, busy} !== 6'b010001 || dl_wr_addr !== '0) begin
            n_err++; $display("FAIL midrst_outputs: got rdy/we/me/pm/ov/busy=%b addr=%0d expected 010001 0", {in_ready, dl_we, mac_en, phase_min, out_valid, busy}, dl_wr_addr);
        end
        tick(); if (out_valid) saw_valid = 1'b1;
        tick(); if (out_valid) saw_valid = 1'b1;
        rst_n = 1'b1;
        hist.delete(); n_acc = 0;
        while (!in_ready && c < BOUND) begin
            if (out_valid || !dl_we) saw_valid = 1'b1;
            tick(); c++;
        end
        n_vec++; if (c != N || saw_valid) begin n_err++; $display("FAIL midrst_init: got %0d cycles bad=%0b expected %0d 0", c, saw_valid, N); end
        send_sample(1234, lat, fout, ok);
        exp_out = golden();
        n_vec++; if (!ok || lat != N + 2 || fout != exp_out) begin n_err++; $display("FAIL midrst_fresh: got %0d lat=%0d expected %0d lat=%0d", fout, lat, exp_out, N + 2); end
        $display("txn reset_mid_mac: fresh out=%0d", fout);
    endtask

    task automatic test_random();
        int lat, fout, s, exp_out, gap;
        bit ok;
        rand_coeffs();
        for (int t = 0; t < 200; t++) begin
            gap = int'($urandom_range(2, 0));
            for (int g = 0; g < gap; g++) tick();
            s = int'($urandom_range(65535, 0)) - 32768;
            send_sample(s, lat, fout, ok);
            exp_out = golden();
            n_vec++; if (!ok || lat != N + 2 || fout != exp_out) begin n_err++; $display("FAIL rand%0d: got %0d lat=%0d expected %0d lat=%0d", t, fout, lat, exp_out, N + 2); end
            $display("txn rand%0d: sample=%0d out=%0d expected=%0d", t, s, fout, exp_out);
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_sample = '0; clr_overrun = 1'b0;
        hist.delete(); n_acc = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_overrun();
        test_reset_mid_mac();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
